tm_tape_window: RTL and testbench
=================================

// Module: tm_tape_window
// PURPOSE
//  Three-cell tape cache (L/C/R) around the head, between the TM core and the backing tape SRAM.
//  Consumes pred_r/pred_l from the tape direction predictor to prefetch the neighbour the head will
//  most likely move onto next. Writes back evicted dirty cells.
//  Stalls the core (ready_o low) only when the cell under the head is not yet resident.
// PARAMETERS
//  ADDR_BITS  8  tape address width; tape is circular, addresses wrap modulo 2**ADDR_BITS (min 2)
//  SYM_BITS   2  bits per tape symbol
//  BLANK      0  symbol driven on sym_o while C invalid
// PORTS
//  clk         in   1          single clock; all state updates on posedge
//  rst_n       in   1          reset, asynchronous, active-low
//  move_i      in   1          core requests head move (accepted when move_i & ready_o)
//  dir_i       in   1          1 = right (+1), 0 = left (-1)
//  write_i     in   1          write wsym_i into C (with or without move), gated by ready_o
//  wsym_i      in   SYM_BITS   symbol to write
//  pred_r_i    in   1          predictor: strong-right
//  pred_l_i    in   1          predictor: strong-left
//  ready_o     out  1          C valid & no writeback pending
//  sym_o       out  SYM_BITS   symbol under head (C.data, BLANK if C invalid)
//  head_o      out  ADDR_BITS  current head address
//  mem_req_o   out  1          memory request, held high until mem_ack_i
//  mem_we_o    out  1          1 = writeback, 0 = fetch; stable while mem_req_o
//  mem_addr_o  out  ADDR_BITS  request address; stable while mem_req_o
//  mem_wdata_o out  SYM_BITS   writeback data; stable while mem_req_o
//  mem_ack_i   in   1          one-cycle completion pulse, only while mem_req_o high
//  mem_rdata_i in   SYM_BITS   fetch data, valid in ack cycle
// BEHAVIOUR
//  - Reset: head=0, L/C/R {valid,dirty}=0, evict buffer empty, mem_req_o=0, mem_* outputs 0,
//    ready_o=0, sym_o=BLANK. Asserting rst_n low mid-transaction abandons it; no retry.
//  - Slot addrs: L=head-1, C=head, R=head+1 (mod 2**ADDR_BITS).
//  - Write (accepted, with or without move): C.data<=wsym_i, C.dirty<=1, applied before any shift.
//  - Move right: evict=L if L.valid&dirty; L<=C; C<=R; R<=invalid; head+1.
//  - Move left: mirror (evict R; R<=C; C<=L; L<=invalid; head-1).
//  - A clean evicted cell is dropped.
//  - If the new C is invalid, ready_o falls the next cycle and stays low until C is filled.
//  - Mem FSM states: IDLE, FETCH, WBACK; one transaction outstanding max.
//  - Issue decision in IDLE, in priority order:
//    (1) fetch C if invalid
//    (2) writeback evict buffer
//    (3) pred_r_i & !R.valid -> fetch R; pred_l_i & !L.valid -> fetch L
//    (4) no prediction: fetch R if invalid, else L if invalid
//    (5) stay IDLE
//  - mem_req_o is asserted the cycle after the decision; the FSM returns to IDLE in the ack cycle.
//  - Fetch completion: the tag is the absolute address latched at issue. In the ack cycle it is
//    matched against the current L/C/R addrs. The matching slot, if invalid, is filled
//    (valid=1, dirty=0); no match -> data discarded. Head may move while a fetch is in flight.
//  - Writeback completion: evict buffer cleared in the ack cycle; ready_o may rise the same cycle.
//  - Moves are blocked while the evict buffer is full. Evict and in-flight fetch targets are
//    never the same address (fetches target only invalid slots).
//  - Ack + accepted move in the same cycle: the fill is matched against the PRE-move slot addrs,
//    then the shift is applied.
//  - Head wrap: 2**ADDR_BITS-1 +1 -> 0; 0 -1 -> 2**ADDR_BITS-1.
//  - Zero-latency read: sym_o follows C combinationally from registered state.
// STRUCTURE
//  - tm_pkg: SYM_BITS/ADDR_BITS defaults, BLANK, slot encoding localparams (SLOT_L/C/R/NONE),
//    mem FSM state encoding.
//  - One sub-module, tm_tape_mem_port: req/ack FSM, latched addr/we/wdata/tag; returns fill slot.
//  - Window registers, shift logic, evict buffer and issue priority stay in this module.
// TESTING
//  1 Reset then idle:
//    - fetch addr 0 first, then 1 (R), then 255 (L); ready_o rises the cycle after ack for addr 0.
//    - sym_o = returned data.
//  2 Predicted prefetch:
//    - C valid, R and L invalid, pred_l_i=1 -> next request is fetch addr head-1 (not head+1).
//  3 Dirty eviction:
//    - write 3 at head 5, move right, move right -> writeback addr 5 data 3.
//    - ready_o low until its ack; no move accepted meanwhile.
//  4 Stall on miss:
//    - move right with R invalid -> ready_o=0, sym_o=BLANK, fetch head+1 issued.
//    - ready_o=1 after ack.
//  5 Stale fetch discard:
//    - issue fetch R at head 10, move left before ack.
//    - Ack data 2 for addr 11 -> no slot filled; C/L/R unchanged.
//  6 Wrap + async reset:
//    - head 255 move right -> head_o=0.
//    - Drop rst_n mid-FETCH -> mem_req_o=0 immediately, all slots invalid, head_o=0.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared definitions for the three-cell tape window: default widths, slot encoding
// and the memory-port FSM state type.
package tm_pkg;

  localparam int ADDR_BITS_DEF = 8;
  localparam int SYM_BITS_DEF  = 2;
  localparam int BLANK_DEF     = 0;

  localparam logic [1:0] SLOT_L    = 2'd0;
  localparam logic [1:0] SLOT_C    = 2'd1;
  localparam logic [1:0] SLOT_R    = 2'd2;
  localparam logic [1:0] SLOT_NONE = 2'd3;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_FETCH = 2'd1,
    MEM_WBACK = 2'd2
  } mem_state_e;

endpackage

// File: rtl/tm_tape_mem_port.sv
// Single-outstanding request/ack port to the tape SRAM. Latches the request at issue
// and, on a fetch ack, maps the latched address onto the caller's current L/C/R slots.
module tm_tape_mem_port
  import tm_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SYM_BITS  = SYM_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_i,
  input  logic                 issue_we_i,
  input  logic [ADDR_BITS-1:0] issue_addr_i,
  input  logic [SYM_BITS-1:0]  issue_wdata_i,
  input  logic [ADDR_BITS-1:0] head_i,
  input  logic                 mem_ack_i,
  input  logic [SYM_BITS-1:0]  mem_rdata_i,
  output logic                 idle_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [SYM_BITS-1:0]  mem_wdata_o,
  output logic                 fill_vld_o,
  output logic [1:0]           fill_slot_o,
  output logic [SYM_BITS-1:0]  fill_data_o,
  output logic                 wb_done_o
);

  mem_state_e           state_q, state_d;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [SYM_BITS-1:0]  wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle_o && issue_i) begin
        we_q    <= issue_we_i;
        addr_q  <= issue_addr_i;
        wdata_q <= issue_wdata_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_o      = 1'b0;
    fill_vld_o  = 1'b0;
    wb_done_o   = 1'b0;
    fill_slot_o = SLOT_NONE;
    case (state_q)
      MEM_IDLE: begin
        idle_o = 1'b1;
        if (issue_i) state_d = issue_we_i ? MEM_WBACK : MEM_FETCH;
      end
      MEM_FETCH: if (mem_ack_i) begin
        state_d    = MEM_IDLE;
        fill_vld_o = 1'b1;
      end
      MEM_WBACK: if (mem_ack_i) begin
        state_d   = MEM_IDLE;
        wb_done_o = 1'b1;
      end
      default: state_d = MEM_IDLE;
    endcase
    // The tag is absolute, so a head that moved during the fetch still finds its slot
    if (addr_q == head_i - ADDR_BITS'(1))      fill_slot_o = SLOT_L;
    else if (addr_q == head_i)                 fill_slot_o = SLOT_C;
    else if (addr_q == head_i + ADDR_BITS'(1)) fill_slot_o = SLOT_R;
  end

  assign mem_req_o   = (state_q != MEM_IDLE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign fill_data_o = mem_rdata_i;

endmodule

// File: rtl/tm_tape_window.sv
// Three-cell L/C/R tape cache around the TM head with predictor-driven prefetch and
// dirty writeback; the core stalls only while the cell under the head is missing.
module tm_tape_window
  import tm_pkg::*;
#(
  parameter int                ADDR_BITS = ADDR_BITS_DEF,
  parameter int                SYM_BITS  = SYM_BITS_DEF,
  parameter logic [SYM_BITS-1:0] BLANK   = SYM_BITS'(BLANK_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 move_i,
  input  logic                 dir_i,
  input  logic                 write_i,
  input  logic [SYM_BITS-1:0]  wsym_i,
  input  logic                 pred_r_i,
  input  logic                 pred_l_i,
  output logic                 ready_o,
  output logic [SYM_BITS-1:0]  sym_o,
  output logic [ADDR_BITS-1:0] head_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [SYM_BITS-1:0]  mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [SYM_BITS-1:0]  mem_rdata_i
);

  logic [ADDR_BITS-1:0] head_q, head_d;
  logic [2:0]           vld_q, vld_d, dty_q, dty_d;
  logic [SYM_BITS-1:0]  dat_q [3];
  logic [SYM_BITS-1:0]  dat_d [3];
  logic                 evict_vld_q, ev_load;
  logic [ADDR_BITS-1:0] evict_addr_q, ev_addr_d;
  logic [SYM_BITS-1:0]  evict_dat_q, ev_dat_d;

  logic                 port_idle, fill_vld, wb_done;
  logic [1:0]           fill_slot;
  logic [SYM_BITS-1:0]  fill_data;
  logic                 issue, issue_we;
  logic [ADDR_BITS-1:0] issue_addr;
  logic [SYM_BITS-1:0]  issue_wdata;
  logic                 acc_move, acc_write;

  tm_tape_mem_port #(
    .ADDR_BITS(ADDR_BITS),
    .SYM_BITS (SYM_BITS)
  ) u_mem_port (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_i      (issue),
    .issue_we_i   (issue_we),
    .issue_addr_i (issue_addr),
    .issue_wdata_i(issue_wdata),
    .head_i       (head_q),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .idle_o       (port_idle),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .fill_vld_o   (fill_vld),
    .fill_slot_o  (fill_slot),
    .fill_data_o  (fill_data),
    .wb_done_o    (wb_done)
  );

  // A writeback ack frees the evict buffer in the same cycle, so ready may rise with it
  assign ready_o   = vld_q[SLOT_C] & ~(evict_vld_q & ~wb_done);
  assign acc_move  = move_i & ready_o;
  assign acc_write = write_i & ready_o;
  assign sym_o     = vld_q[SLOT_C] ? dat_q[SLOT_C] : BLANK;
  assign head_o    = head_q;

  always_comb begin
    vld_d     = vld_q;
    dty_d     = dty_q;
    dat_d     = dat_q;
    head_d    = head_q;
    ev_load   = 1'b0;
    ev_addr_d = head_q - ADDR_BITS'(1);
    ev_dat_d  = dat_q[SLOT_L];
    if (acc_write) begin
      dat_d[SLOT_C] = wsym_i;
      dty_d[SLOT_C] = 1'b1;
    end
    for (int s = 0; s < 3; s++) begin
      if (fill_vld && fill_slot == 2'(s) && !vld_q[s]) begin
        vld_d[s] = 1'b1;
        dty_d[s] = 1'b0;
        dat_d[s] = fill_data;
      end
    end
    // Shift operates on the post-write, post-fill window
    if (acc_move && dir_i) begin
      ev_load       = vld_d[SLOT_L] & dty_d[SLOT_L];
      ev_addr_d     = head_q - ADDR_BITS'(1);
      ev_dat_d      = dat_d[SLOT_L];
      vld_d         = {1'b0, vld_d[SLOT_R], vld_d[SLOT_C]};
      dty_d         = {1'b0, dty_d[SLOT_R], dty_d[SLOT_C]};
      dat_d[SLOT_L] = dat_d[SLOT_C];
      dat_d[SLOT_C] = dat_d[SLOT_R];
      head_d        = head_q + ADDR_BITS'(1);
    end else if (acc_move) begin
      ev_load       = vld_d[SLOT_R] & dty_d[SLOT_R];
      ev_addr_d     = head_q + ADDR_BITS'(1);
      ev_dat_d      = dat_d[SLOT_R];
      vld_d         = {vld_d[SLOT_C], vld_d[SLOT_L], 1'b0};
      dty_d         = {dty_d[SLOT_C], dty_d[SLOT_L], 1'b0};
      dat_d[SLOT_R] = dat_d[SLOT_C];
      dat_d[SLOT_C] = dat_d[SLOT_L];
      head_d        = head_q - ADDR_BITS'(1);
    end
  end

  always_comb begin
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = head_q;
    issue_wdata = '0;
    if (port_idle) begin
      if (!vld_q[SLOT_C]) begin
        issue = 1'b1;
      end else if (evict_vld_q) begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = evict_addr_q;
        issue_wdata = evict_dat_q;
      end else if ((pred_r_i && !vld_q[SLOT_R]) ||
                   (!pred_r_i && !pred_l_i && !vld_q[SLOT_R])) begin
        issue      = 1'b1;
        issue_addr = head_q + ADDR_BITS'(1);
      end else if ((pred_l_i && !vld_q[SLOT_L]) ||
                   (!pred_r_i && !pred_l_i && !vld_q[SLOT_L])) begin
        issue      = 1'b1;
        issue_addr = head_q - ADDR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      vld_q       <= '0;
      dty_q       <= '0;
      evict_vld_q <= 1'b0;
    end else begin
      head_q <= head_d;
      vld_q  <= vld_d;
      dty_q  <= dty_d;
      if (ev_load)      evict_vld_q <= 1'b1;
      else if (wb_done) evict_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
    if (ev_load) begin
      evict_addr_q <= ev_addr_d;
      evict_dat_q  <= ev_dat_d;
    end
  end

endmodule

// File: tb/tb_tm_tape_window.sv
// Bench for tm_tape_window: directed scenarios plus a random walk checked against a
// plain tape-array model with a random-latency SRAM responder.
module tb_tm_tape_window;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       move_i = 1'b0, dir_i = 1'b0, write_i = 1'b0;
  logic [1:0] wsym_i = '0;
  logic       pred_r_i = 1'b0, pred_l_i = 1'b0;
  logic       ready_o, mem_req_o, mem_we_o;
  logic [1:0] sym_o, mem_wdata_o;
  logic [7:0] head_o, mem_addr_o;
  logic       mem_ack_i = 1'b0;
  logic [1:0] mem_rdata_i = '0;

  int checks = 0, errors = 0;
  logic [1:0] sram [256];
  logic [1:0] tape [256];

  always #5 clk = ~clk;

  tm_tape_window dut (
    .clk(clk), .rst_n(rst_n), .move_i(move_i), .dir_i(dir_i), .write_i(write_i),
    .wsym_i(wsym_i), .pred_r_i(pred_r_i), .pred_l_i(pred_l_i), .ready_o(ready_o),
    .sym_o(sym_o), .head_o(head_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  task automatic do_reset();
    rst_n = 1'b0; move_i = 0; dir_i = 0; write_i = 0; wsym_i = '0;
    pred_r_i = 0; pred_l_i = 0; mem_ack_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) tape[i] = sram[i];
  endtask

  task automatic wait_req(output int n);
    n = -1;
    for (int i = 0; i < 30; i++) begin
      if (mem_req_o) begin n = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic serve();
    mem_ack_i = 1'b1;
    mem_rdata_i = sram[mem_addr_o];
    if (mem_we_o) sram[mem_addr_o] = mem_wdata_o;
    @(negedge clk);
    mem_ack_i = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      if (mem_req_o) serve();
      else @(negedge clk);
    end
  endtask

  task automatic do_move(input logic d);
    move_i = 1'b1; dir_i = d;
    @(negedge clk);
    move_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    sram[0] = 2'd2; sram[1] = 2'd1; sram[255] = 2'd3;
    do_reset();
    checks++; if (head_o !== 8'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", head_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++; if (sym_o !== 2'd0) begin errors++; $display("FAIL reset_sym: got %0d expected 0", sym_o); end
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 12'd0) begin
      errors++; $display("FAIL reset_mem: got req=%b we=%b addr=%0d wdata=%0d expected all 0",
                         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'd0) begin
      errors++; $display("FAIL first_fetch: got req=%b we=%b addr=%0d expected fetch 0", mem_req_o, mem_we_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = sram[0];
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_in_ack: got %b expected 0", ready_o); end
    @(negedge clk);
    mem_ack_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_ack: got %b expected 1", ready_o); end
    checks++; if (sym_o !== 2'd2) begin errors++; $display("FAIL sym_after_fill: got %0d expected 2", sym_o); end
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'd1) begin
      errors++; $display("FAIL second_fetch: got req=%b addr=%0d expected fetch 1", mem_req_o, mem_addr_o); end
    serve();
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'd255) begin
      errors++; $display("FAIL third_fetch: got req=%b addr=%0d expected fetch 255", mem_req_o, mem_addr_o); end
    serve();
  endtask

  task automatic test_predicted_prefetch();
    int n;
    do_reset();
    pred_l_i = 1'b1;
    wait_req(n);
    checks++; if (n < 0 || mem_addr_o !== 8'd0) begin errors++; $display("FAIL pred_c_fetch: got addr=%0d expected 0", mem_addr_o); end
    serve();
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'd255) begin
      errors++; $display("FAIL pred_l_fetch: got req=%b addr=%0d expected fetch 255", mem_req_o, mem_addr_o); end
    serve();
    pred_l_i = 1'b0;
  endtask

  task automatic test_dirty_eviction();
    int n;
    do_reset();
    settle(10);
    for (int i = 0; i < 5; i++) begin do_move(1'b1); settle(8); end
    checks++; if (head_o !== 8'd5) begin errors++; $display("FAIL evict_head5: got %0d expected 5", head_o); end
    write_i = 1'b1; wsym_i = 2'd3; tape[5] = 2'd3;
    @(negedge clk);
    write_i = 1'b0;
    settle(2);
    do_move(1'b1); settle(8);
    do_move(1'b1);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL evict_stall: got ready=%b expected 0", ready_o); end
    move_i = 1'b1; dir_i = 1'b1;
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b1 || mem_addr_o !== 8'd5 || mem_wdata_o !== 2'd3) begin
      errors++; $display("FAIL writeback: got req=%b we=%b addr=%0d data=%0d expected wb addr 5 data 3",
                         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
    checks++; if (ready_o !== 1'b0 || head_o !== 8'd7) begin
      errors++; $display("FAIL wb_blocks_move: got ready=%b head=%0d expected 0/7", ready_o, head_o); end
    move_i = 1'b0;
    serve();
    checks++; if (ready_o !== 1'b1 || head_o !== 8'd7) begin
      errors++; $display("FAIL wb_release: got ready=%b head=%0d expected 1/7", ready_o, head_o); end
    settle(6);
  endtask

  task automatic test_stall_on_miss();
    int n;
    sram[1] = 2'd3;
    do_reset();
    pred_l_i = 1'b1;
    settle(8);
    checks++; if (ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL miss_setup: got ready=%b req=%b expected 1/0", ready_o, mem_req_o); end
    do_move(1'b1);
    checks++; if (ready_o !== 1'b0 || sym_o !== 2'd0 || head_o !== 8'd1) begin
      errors++; $display("FAIL miss_stall: got ready=%b sym=%0d head=%0d expected 0/0/1", ready_o, sym_o, head_o); end
    wait_req(n);
    checks++; if (n < 0 || mem_we_o !== 1'b0 || mem_addr_o !== 8'd1) begin
      errors++; $display("FAIL miss_fetch: got req=%b addr=%0d expected fetch 1", mem_req_o, mem_addr_o); end
    serve();
    checks++; if (ready_o !== 1'b1 || sym_o !== 2'd3) begin
      errors++; $display("FAIL miss_fill: got ready=%b sym=%0d expected 1/3", ready_o, sym_o); end
    pred_l_i = 1'b0;
  endtask

  task automatic test_stale_discard();
    int n;
    sram[10] = 2'd1; sram[11] = 2'd3;
    do_reset();
    settle(10);
    for (int i = 0; i < 10; i++) begin do_move(1'b1); settle(8); end
    // undo the last settle's fetch of 11 by stepping back and forth once
    do_move(1'b0); settle(8);
    checks++; if (head_o !== 8'd9) begin errors++; $display("FAIL stale_head9: got %0d expected 9", head_o); end
    do_move(1'b1);
    wait_req(n);
    checks++; if (n < 0 || mem_addr_o !== 8'd11) begin errors++; $display("FAIL stale_issue: got addr=%0d expected 11", mem_addr_o); end
    do_move(1'b0);
    mem_ack_i = 1'b1; mem_rdata_i = 2'd2;
    @(negedge clk);
    mem_ack_i = 1'b0;
    checks++; if (head_o !== 8'd9 || ready_o !== 1'b1 || sym_o !== sram[9]) begin
      errors++; $display("FAIL stale_c: got head=%0d ready=%b sym=%0d expected 9/1/%0d", head_o, ready_o, sym_o, sram[9]); end
    settle(8);
    do_move(1'b1);
    checks++; if (ready_o !== 1'b1 || sym_o !== 2'd1) begin
      errors++; $display("FAIL stale_r: got ready=%b sym=%0d expected 1/1", ready_o, sym_o); end
    wait_req(n);
    checks++; if (n < 0 || mem_addr_o !== 8'd11) begin errors++; $display("FAIL stale_refetch: got addr=%0d expected 11", mem_addr_o); end
    settle(6);
  endtask

  task automatic test_wrap_async_reset();
    int n;
    do_reset();
    settle(10);
    do_move(1'b0);
    checks++; if (head_o !== 8'd255) begin errors++; $display("FAIL wrap_left: got %0d expected 255", head_o); end
    settle(8);
    do_move(1'b1);
    checks++; if (head_o !== 8'd0) begin errors++; $display("FAIL wrap_right: got %0d expected 0", head_o); end
    settle(8);
    do_move(1'b1);
    wait_req(n);
    checks++; if (n < 0 || mem_addr_o !== 8'd2) begin errors++; $display("FAIL wrap_fetch: got addr=%0d expected 2", mem_addr_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || head_o !== 8'd0 || ready_o !== 1'b0 || sym_o !== 2'd0 || mem_addr_o !== 8'd0) begin
      errors++; $display("FAIL async_reset: got req=%b head=%0d ready=%b sym=%0d addr=%0d expected all 0",
                         mem_req_o, head_o, ready_o, sym_o, mem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(n);
    checks++; if (n < 0 || mem_addr_o !== 8'd0) begin errors++; $display("FAIL no_retry: got addr=%0d expected 0", mem_addr_o); end
    serve();
  endtask

  task automatic test_random();
    int lat, stall;
    logic [7:0] mh;
    do_reset();
    mh = 8'd0; lat = 0; stall = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (head_o !== mh) begin errors++; $display("FAIL rand_head: got %0d expected %0d", head_o, mh); end
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (lat == 0) begin
          if (mem_we_o) begin
            checks++; if (mem_wdata_o !== tape[mem_addr_o]) begin
              errors++; $display("FAIL rand_wb: addr %0d got %0d expected %0d", mem_addr_o, mem_wdata_o, tape[mem_addr_o]); end
            sram[mem_addr_o] = mem_wdata_o;
          end else mem_rdata_i = sram[mem_addr_o];
          mem_ack_i = 1'b1;
          lat = $urandom_range(0, 3);
        end else lat--;
      end
      pred_r_i = ($urandom_range(0, 3) == 0);
      pred_l_i = ($urandom_range(0, 3) == 0);
      move_i   = 1'($urandom_range(0, 1));
      dir_i    = 1'($urandom_range(0, 1));
      write_i  = ($urandom_range(0, 2) == 0);
      wsym_i   = 2'($urandom_range(0, 3));
      #1;
      if (ready_o) begin
        stall = 0;
        checks++; if (sym_o !== tape[mh]) begin errors++; $display("FAIL rand_sym: head %0d got %0d expected %0d", mh, sym_o, tape[mh]); end
        if (write_i) tape[mh] = wsym_i;
        if (move_i) mh = dir_i ? mh + 8'd1 : mh - 8'd1;
      end else begin
        stall++;
        if (stall > 40) begin
          checks++; errors++;
          $display("FAIL rand_stall: ready low %0d cycles expected at most 40", stall);
          break;
        end
      end
      @(negedge clk);
    end
    move_i = 0; write_i = 0; mem_ack_i = 0; pred_r_i = 0; pred_l_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 2'($urandom_range(0, 3));
    test_reset();
    test_predicted_prefetch();
    test_dirty_eviction();
    test_stall_on_miss();
    test_stale_discard();
    test_wrap_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
